// File: rtl/jt12_ch_sum.sv
// Purpose: serial channel accumulator; sums up to CHANNELS masked signed slots per frame and saturates to DW bits.
// Latency: pre/sample update on the same edge that accepts the closing slot; sample is one clk wide.
// Backpressure: none; every cycle with cen & ch_valid is accepted unconditionally.
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   cen          clock enable; slots are accepted only when high
//   ch_valid     ch_data carries a channel sample this cycle
//   ch_last      marks the final slot of a frame (only meaningful with ch_valid)
//   ch_data      signed channel sample, DW bits
//   ch_mask      per-slot include mask (bit i = slot i), sampled on each accept
//   clr_clip     clears the sticky clip flag
//   pre          held signed saturated frame sum
//   sample       one-clk strobe: pre was updated on the preceding edge
//   clip         sticky: some frame sum needed clamping
//   sync_err     one-clk strobe: frame boundary and slot counter disagreed
module jt12_ch_sum #(
    parameter int CHANNELS = 6,
    parameter int DW       = 14,
    parameter int ACCW     = 17
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cen,
    input  logic                ch_valid,
    input  logic                ch_last,
    input  logic [DW-1:0]       ch_data,
    input  logic [CHANNELS-1:0] ch_mask,
    input  logic                clr_clip,
    output logic [DW-1:0]       pre,
    output logic                sample,
    output logic                clip,
    output logic                sync_err
);

    // Saturation bounds expressed at accumulator width so the comparison
    // is done on the full, unwrapped sum.
    localparam logic signed [ACCW-1:0] SAT_MAX =
        {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_MIN =
        {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic [2:0] LAST_SLOT = 3'(CHANNELS-1);

    logic signed [ACCW-1:0] acc;
    logic [2:0]             cnt;

    logic                   accept;
    logic                   slot_end;
    logic                   closing;
    logic [7:0]             mask_ext;
    logic signed [ACCW-1:0] term;
    logic signed [ACCW-1:0] sum;
    logic                   sat_hi;
    logic                   sat_lo;
    logic [DW-1:0]          sat_val;

    always_comb begin
        accept   = cen & ch_valid;
        slot_end = (cnt == LAST_SLOT);
        closing  = accept & (ch_last | slot_end);

        // Mask widened to the full 3-bit counter range so any cnt value
        // indexes a defined bit; slots beyond CHANNELS-1 never occur.
        mask_ext                 = '0;
        mask_ext[CHANNELS-1:0]   = ch_mask;

        term = '0;
        if (mask_ext[cnt]) begin
            term = {{(ACCW-DW){ch_data[DW-1]}}, ch_data};
        end

        sum    = acc + term;
        sat_hi = (sum > SAT_MAX);
        sat_lo = (sum < SAT_MIN);

        if (sat_hi) begin
            sat_val = SAT_MAX[DW-1:0];
        end else if (sat_lo) begin
            sat_val = SAT_MIN[DW-1:0];
        end else begin
            sat_val = sum[DW-1:0];
        end
    end

    // Accumulator and slot counter. A closing slot restarts both so the
    // next accept always lands on slot 0, including after a short frame
    // or a counter wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (closing) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            acc <= sum;
            cnt <= cnt + 3'd1;
        end
    end

    // Frame output register and strobes. The strobes default low every
    // cycle so they stay one clk wide whatever cen does.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre      <= '0;
            sample   <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            sample   <= 1'b0;
            sync_err <= 1'b0;
            if (closing) begin
                pre      <= sat_val;
                sample   <= 1'b1;
                // Short frame (ch_last early) or missing ch_last on the
                // final slot: exactly one of the two closing causes holds.
                sync_err <= ch_last ^ slot_end;
            end
        end
    end

    // Sticky clip flag; a new clip event overrides a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            clip <= 1'b0;
        end else if (closing && (sat_hi || sat_lo)) begin
            clip <= 1'b1;
        end else if (clr_clip) begin
            clip <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jt12_ch_sum.sv
module tb_jt12_ch_sum;

    localparam int CHANNELS = 6;
    localparam int DW       = 14;
    localparam int ACCW     = 17;

    logic                clk;
    logic                rst;
    logic                cen;
    logic                ch_valid;
    logic                ch_last;
    logic [DW-1:0]       ch_data;
    logic [CHANNELS-1:0] ch_mask;
    logic                clr_clip;
    logic [DW-1:0]       pre;
    logic                sample;
    logic                clip;
    logic                sync_err;

    int n_tests;
    int n_fail;

    jt12_ch_sum #(.CHANNELS(CHANNELS), .DW(DW), .ACCW(ACCW)) dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .ch_valid (ch_valid),
        .ch_last  (ch_last),
        .ch_data  (ch_data),
        .ch_mask  (ch_mask),
        .clr_clip (clr_clip),
        .pre      (pre),
        .sample   (sample),
        .clip     (clip),
        .sync_err (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pre_s();
        return int'($signed(pre));
    endfunction

    // One accepted slot; outputs are sampled 1 time unit after the edge.
    task automatic send(input int d, input logic last, input logic [CHANNELS-1:0] m,
                        input logic clr);
        @(negedge clk);
        cen      = 1'b1;
        ch_valid = 1'b1;
        ch_last  = last;
        ch_data  = DW'(d);
        ch_mask  = m;
        clr_clip = clr;
        @(posedge clk);
        #1;
        ch_valid = 1'b0;
        ch_last  = 1'b0;
        clr_clip = 1'b0;
    endtask

    // Cycle that must be ignored: valid/last without cen, or last without valid.
    task automatic ignored(input logic en, input logic vld);
        @(negedge clk);
        cen      = en;
        ch_valid = vld;
        ch_last  = 1'b1;
        ch_data  = DW'(1000);
        ch_mask  = '1;
        @(posedge clk);
        #1;
        cen      = 1'b1;
        ch_valid = 1'b0;
        ch_last  = 1'b0;
    endtask

    // Six equal slots; ch_last optionally on the sixth, clr_clip optionally
    // on the closing edge. Checks that no strobe fires before the close.
    task automatic frame6(input string tag, input int d, input logic [CHANNELS-1:0] m,
                          input logic last, input logic clr);
        for (int i = 0; i < 5; i++) begin
            send(d, 1'b0, m, 1'b0);
            if (i == 4) chk({tag, "_nosample_early"}, int'(sample), 0);
        end
        send(d, last, m, clr);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        cen      = 1'b0;
        ch_valid = 1'b0;
        ch_last  = 1'b0;
        ch_data  = '0;
        ch_mask  = '0;
        clr_clip = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pre", pre_s(), 0);
        chk("rst_sample", int'(sample), 0);
        chk("rst_clip", int'(clip), 0);
        chk("rst_sync_err", int'(sync_err), 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic sum: 100+...+600 = 2100
        for (int i = 0; i < 6; i++) begin
            send((i + 1) * 100, (i == 5), 6'h3F, 1'b0);
            if (i < 5) chk("basic_nosample", int'(sample), 0);
        end
        chk("basic_pre", pre_s(), 2100);
        chk("basic_sample", int'(sample), 1);
        chk("basic_clip", int'(clip), 0);
        chk("basic_sync_err", int'(sync_err), 0);
        idle_cycle();
        chk("basic_sample_1clk", int'(sample), 0);
        chk("basic_pre_held", pre_s(), 2100);

        // Positive saturation: 6*8191 = 49146 -> 8191
        frame6("satp", 8191, 6'h3F, 1'b1, 1'b0);
        chk("satp_pre", pre_s(), 8191);
        chk("satp_clip", int'(clip), 1);
        idle_cycle();
        chk("satp_clip_sticky", int'(clip), 1);

        // Negative saturation: 6*-8192 -> -8192
        frame6("satn", -8192, 6'h3F, 1'b1, 1'b0);
        chk("satn_pre", pre_s(), -8192);
        chk("satn_clip", int'(clip), 1);

        // Clear clip alongside a non-clipping frame
        frame6("clr", 1, 6'h3F, 1'b1, 1'b1);
        chk("clr_pre", pre_s(), 6);
        chk("clr_clip", int'(clip), 0);

        // Clip set and clr_clip on the same edge: set wins
        frame6("setwin", 8191, 6'h3F, 1'b1, 1'b1);
        chk("setwin_clip", int'(clip), 1);
        @(negedge clk);
        clr_clip = 1'b1;
        @(posedge clk);
        #1;
        clr_clip = 1'b0;
        chk("clr_idle_clip", int'(clip), 0);

        // Muting: mask 0x05 keeps slots 0 and 2
        frame6("mask05", 1000, 6'h05, 1'b1, 1'b0);
        chk("mask05_pre", pre_s(), 2000);
        frame6("mask00", 1000, 6'h00, 1'b1, 1'b0);
        chk("mask00_pre", pre_s(), 0);
        chk("mask00_sample", int'(sample), 1);

        // Short frame: 10+20+30 with ch_last on the 3rd slot
        send(10, 1'b0, 6'h3F, 1'b0);
        send(20, 1'b0, 6'h3F, 1'b0);
        send(30, 1'b1, 6'h3F, 1'b0);
        chk("short_pre", pre_s(), 60);
        chk("short_sample", int'(sample), 1);
        chk("short_sync_err", int'(sync_err), 1);
        idle_cycle();
        chk("short_sync_err_1clk", int'(sync_err), 0);
        // Next frame must start at slot 0: mask 0x01 only counts slot 0
        send(5, 1'b0, 6'h01, 1'b0);
        for (int i = 0; i < 4; i++) send(100, 1'b0, 6'h01, 1'b0);
        send(100, 1'b1, 6'h01, 1'b0);
        chk("after_short_slot0", pre_s(), 5);
        frame6("after_short", 1, 6'h3F, 1'b1, 1'b0);
        chk("after_short_pre", pre_s(), 6);
        chk("after_short_sync_err", int'(sync_err), 0);

        // Missing ch_last: closes at slot 5 with sync_err, counter wraps
        frame6("nolast", 5, 6'h3F, 1'b0, 1'b0);
        chk("nolast_pre", pre_s(), 30);
        chk("nolast_sample", int'(sample), 1);
        chk("nolast_sync_err", int'(sync_err), 1);
        for (int i = 0; i < 6; i++) send(i + 1, (i == 5), 6'h3F, 1'b0);
        chk("wrap_pre", pre_s(), 21);
        chk("wrap_sync_err", int'(sync_err), 0);

        // cen low / ch_last without ch_valid must have no effect
        for (int i = 0; i < 6; i++) begin
            send(2, (i == 5), 6'h3F, 1'b0);
            if (i < 5) begin
                ignored(1'b0, 1'b1);
                chk("ign_cen_sample", int'(sample), 0);
                ignored(1'b1, 1'b0);
                chk("ign_vld_sample", int'(sample), 0);
            end
        end
        chk("ign_pre", pre_s(), 12);
        chk("ign_sync_err", int'(sync_err), 0);

        // Reset mid-frame, with a would-be closing slot presented during rst
        for (int i = 0; i < 3; i++) send(50, 1'b0, 6'h3F, 1'b0);
        @(negedge clk);
        rst      = 1'b1;
        cen      = 1'b1;
        ch_valid = 1'b1;
        ch_last  = 1'b1;
        ch_data  = DW'(50);
        @(posedge clk);
        #1;
        chk("midrst_pre", pre_s(), 0);
        chk("midrst_sample", int'(sample), 0);
        chk("midrst_sync_err", int'(sync_err), 0);
        ch_valid = 1'b0;
        ch_last  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("postrst_sample", int'(sample), 0);
        frame6("postrst", 7, 6'h3F, 1'b1, 1'b0);
        chk("postrst_pre", pre_s(), 42);
        chk("postrst_sample", int'(sample), 1);
        chk("postrst_sync_err", int'(sync_err), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jt12_ch_sum.md
Name: jt12_ch_sum

Overview:
Serial channel accumulator that sits directly upstream of the output amplifier stage. It receives one signed channel sample per accepted slot, up to CHANNELS slots per frame, and sums them with per-channel muting. It saturates each frame sum to the amplifier input width and presents it as a held `pre` word with a one-cycle `sample` strobe.

Parameters:
CHANNELS, 6, slots per frame (2..8); slot counter is 3 bits
DW, 14, channel input width and output `pre` width (signed)
ACCW, 17, internal accumulator width; must be >= DW + ceil(log2(CHANNELS))

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cen  in  1  clock enable; slots are accepted only when high
ch_valid  in  1  ch_data holds a channel sample this cycle
ch_last  in  1  qualifies ch_valid; marks final slot of frame
ch_data  in  DW  signed channel sample
ch_mask  in  CHANNELS  bit i = 1 includes slot i in the sum; 0 mutes it
clr_clip  in  1  clears sticky clip flag
pre  out  DW  signed saturated frame sum, held between frames
sample  out  1  one-clk pulse: pre was updated on the preceding edge
clip  out  1  sticky: some frame sum saturated
sync_err  out  1  one-clk pulse: frame boundary mismatch

Behaviour:
- Reset is synchronous and active-high; all state is on clk.
  - On rst: acc=0, cnt=0, pre=0, sample=0, clip=0, sync_err=0.
  - rst mid-frame discards the partial sum and produces no sample.
  - rst has priority over every other input.
- A slot is accepted on an edge where cen & ch_valid = 1. Nothing changes on cycles with no accept, except the one-cycle pulse outputs, which clear.
- Term for slot cnt:
  - ch_mask[cnt] ? sign_extend(ch_data, ACCW) : 0.
  - A masked slot still advances cnt.
- Non-closing accept: acc <= acc + term; cnt <= cnt+1.
- Closing accept occurs when ch_last=1 or cnt==CHANNELS-1.
  - sum = acc + term (full ACCW, no wrap).
  - pre <= sat(sum): clamp to [-2^(DW-1), 2^(DW-1)-1], i.e. [-8192, 8191] at default.
  - sample <= 1 for exactly one clk.
  - acc <= 0; cnt <= 0.
  - If clamping occurred, clip <= 1.
- sync_err <= 1 for one clk on a closing accept when:
  - ch_last=1 and cnt != CHANNELS-1 (short frame, still closes), or
  - cnt==CHANNELS-1 and ch_last=0 (frame closes and counter wraps to 0).
- Latency: pre/sample change on the same edge that accepts the closing slot.
  - sample is a single clk wide regardless of cen.
  - pre is stable until the next closing accept.
- clip is sticky and cleared by clr_clip. If a clip set and clr_clip coincide, the set wins.
- cen low while ch_valid is high: the slot is ignored, with no partial effects.
- ch_mask is sampled per accept and may change mid-frame.
- ch_last without ch_valid is ignored.

Test Plan:
- Reset then six accepts, data 100,200,300,400,500,600, mask 3F, ch_last on slot 5 -> pre=2100, one-clk sample pulse on the 6th accept edge, clip=0, sync_err=0.
- Six accepts of +8191, mask 3F -> pre=8191, clip=1 persists. Then six accepts of -8192 -> pre=-8192. Pulse clr_clip on a non-clipping frame -> clip=0. Clip frame with clr_clip on the closing edge -> clip stays 1.
- Data 1000 x6 with mask 0x05 -> pre=2000. With mask 0x00 -> pre=0 and sample still pulses.
- ch_last on 3rd accept of 10,20,30 -> pre=60, sync_err pulse. Next frame of 6 x 1 starts at slot 0 -> pre=6.
- Six accepts without ch_last -> pre=sum, sync_err pulse, cnt wraps. Accepts interleaved with cen=0/ch_valid=1 cycles -> ignored, same pre.
- rst asserted after 3 accepts, then 6 accepts of 7 -> pre=42, no sample during or right after rst. Check pre=0 and sample=0 in the reset cycle.
